soft_reset_requester: RTL and testbench



---
 rtl/soft_reset_pkg.sv | 15 +
 rtl/rst_sync_ff.sv | 23 ++
 rtl/soft_reset_requester.sv | 130 +++++++++++++
 tb/tb_soft_reset_requester.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/soft_reset_pkg.sv
// rtl/soft_reset_pkg.sv - shared types and constants for the soft reset requester
package soft_reset_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    localparam int REQ_CNT_W = 8;
    localparam logic [REQ_CNT_W-1:0] REQ_CNT_MAX = 8'd255;

endpackage

// File: rtl/rst_sync_ff.sv
// rtl/rst_sync_ff.sv - multi-stage synchroniser that resets to 1 (deasserted reset level)
module rst_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/soft_reset_requester.sv
// rtl/soft_reset_requester.sv - REQ/ACK driven external reset pulse with fabric round-trip monitor
module soft_reset_requester
    import soft_reset_pkg::*;
#(
    parameter int PULSE_W     = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    output logic                 ack,
    input  logic                 fabric_reset_n,
    output logic                 ext_rst_n,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [REQ_CNT_W-1:0] req_cnt
);

    localparam int MAX_CYC = (PULSE_W > TIMEOUT_CYC) ? PULSE_W : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 seen_low, seen_low_next;
    logic                 timeout_err_next;
    logic [REQ_CNT_W-1:0] req_cnt_next;
    logic                 fabric_sync;
    logic                 cnt_zero;

    rst_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_fabric_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (fabric_reset_n),
        .q    (fabric_sync)
    );

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            seen_low    <= 1'b0;
            timeout_err <= 1'b0;
            req_cnt     <= '0;
            ext_rst_n   <= 1'b1;
            ack         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            seen_low    <= seen_low_next;
            timeout_err <= timeout_err_next;
            req_cnt     <= req_cnt_next;
            // outputs follow the next state so they change on the same edge as the FSM
            ext_rst_n   <= (state_next != ASSERT);
            ack         <= (state_next == DONE);
            busy        <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        seen_low_next    = seen_low;
        timeout_err_next = timeout_err;
        req_cnt_next     = req_cnt;

        case (state)
            IDLE: begin
                if (req) begin
                    state_next       = ASSERT;
                    timeout_err_next = 1'b0;
                    seen_low_next    = 1'b0;
                    cnt_next         = PULSE_LOAD;
                end
            end
            ASSERT: begin
                if (!fabric_sync) begin
                    seen_low_next = 1'b1;
                end
                if (cnt_zero) begin
                    state_next = (seen_low || !fabric_sync) ? WAIT_HIGH : WAIT_LOW;
                    cnt_next   = TIMEOUT_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!fabric_sync) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = TIMEOUT_LOAD;
                end else if (cnt_zero) begin
                    state_next       = DONE;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WAIT_HIGH: begin
                // a release seen on the expiry cycle still counts as success
                if (fabric_sync) begin
                    state_next = DONE;
                    if (req_cnt != REQ_CNT_MAX) begin
                        req_cnt_next = req_cnt + 1'b1;
                    end
                end else if (cnt_zero) begin
                    state_next       = DONE;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_soft_reset_requester.sv
// tb/tb_soft_reset_requester.sv - randomized self-checking bench with a timeline reference model
module tb_soft_reset_requester;

    localparam int PW  = 16;
    localparam int TO  = 100;
    localparam int SS  = 2;
    localparam int INF = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       fabric = 1'b1;
    logic       ack;
    logic       ext_rst_n;
    logic       busy;
    logic       timeout_err;
    logic [7:0] req_cnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    soft_reset_requester #(
        .PULSE_W    (PW),
        .TIMEOUT_CYC(TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .ack           (ack),
        .fabric_reset_n(fabric),
        .ext_rst_n     (ext_rst_n),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .req_cnt       (req_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Fabric drops after edge a+d and releases after edge a+d+L; the block sees
    // each raw change SS+1 edges later. Returns the edge ACK rises and whether it timed out.
    function automatic void predict(input int a, input int d, input int len, input bit nf,
                                    input bit nr, output int done_edge, output bit to);
        int er, f, h, w;
        er = a + PW;
        if (nf) begin
            done_edge = er + TO;
            to = 1'b1;
            return;
        end
        f = a + d + 1 + SS;
        h = nr ? INF : a + d + len + 1 + SS;
        if (f <= er) begin
            w = er;
        end else if (f <= er + TO) begin
            w = f;
        end else begin
            done_edge = er + TO;
            to = 1'b1;
            return;
        end
        if (h <= w + TO) begin
            done_edge = (h > w + 1) ? h : w + 1;
            to = 1'b0;
        end else begin
            done_edge = w + TO;
            to = 1'b1;
        end
    endfunction

    task automatic run_txn(input int d, input int len, input bit nf, input bit nr,
                           input int hold, input int drop);
        int k, a, er, ackd, dexp;
        bit toexp;
        k = cyc;
        req = 1'b1;
        step();
        a = k + 1;
        chk("ext_fall", int'(ext_rst_n), 0);
        chk("req_latency", cyc, a);
        chk("busy_start", int'(busy), 1);
        chk("terr_cleared", int'(timeout_err), 0);
        er = -1;
        ackd = -1;
        for (int i = 0; i < 3000; i++) begin
            if (!nf && cyc == a + d) fabric = 1'b0;
            if (!nf && !nr && cyc == a + d + len) fabric = 1'b1;
            if (drop >= 0 && cyc == a + drop) req = 1'b0;
            if (er < 0 && ext_rst_n) er = cyc;
            if (ack) begin
                ackd = cyc;
                break;
            end
            step();
        end
        if (ackd < 0) begin
            chk("ack_wait_expired", 0, 1);
        end else begin
            predict(a, d, len, nf, nr, dexp, toexp);
            if (!toexp && model_cnt < 255) model_cnt++;
            chk("pulse_width", er - a, PW);
            chk("ack_edge", ackd - a, dexp - a);
            chk("timeout_err", int'(timeout_err), int'(toexp));
            chk("req_cnt", int'(req_cnt), model_cnt);
            chk("busy_done", int'(busy), 1);
        end
        fabric = 1'b1;
        if (req) begin
            for (int i = 0; i < hold; i++) begin
                step();
                chk("ack_hold", int'(ack), 1);
            end
            req = 1'b0;
        end
        step();
        chk("ack_fall", int'(ack), 0);
        chk("busy_fall", int'(busy), 0);
        repeat (SS + 3) step();
    endtask

    initial begin
        int a;
        repeat (3) step();
        chk("rst_ext", int'(ext_rst_n), 1);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_terr", int'(timeout_err), 0);
        chk("rst_cnt", int'(req_cnt), 0);
        rst_n = 1'b1;
        repeat (3) step();

        // normal: drop 2 after EXT_RST_N falls, release 50 after it rises
        run_txn(2, PW + 50 - 2, 1'b0, 1'b0, 2, -1);
        // fabric never falls
        run_txn(0, 0, 1'b1, 1'b0, 1, -1);
        // fabric stuck low, then a clean request clears the error
        run_txn(2, 0, 1'b0, 1'b1, 0, -1);
        run_txn(1, 10, 1'b0, 1'b0, 0, -1);
        // REQ dropped on cycle 5 of ASSERT
        run_txn(3, 20, 1'b0, 1'b0, 0, 4);
        // late fall seen in WAIT_LOW
        run_txn(30, 40, 1'b0, 1'b0, 0, -1);

        for (int i = 0; i < 30; i++) begin
            int d, len, hold, drop;
            bit nf, nr;
            d    = $urandom_range(0, 40);
            len  = $urandom_range(3, 90);
            nf   = ($urandom_range(0, 9) == 0);
            nr   = ($urandom_range(0, 9) == 0);
            hold = $urandom_range(0, 3);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, PW - 1)) : -1;
            run_txn(d, len, nf, nr, hold, drop);
        end

        // RST_N pulsed on cycle 8 of ASSERT
        req = 1'b1;
        step();
        a = cyc;
        chk("rst_mid_start", int'(ext_rst_n), 0);
        while (cyc < a + 7) step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ext", int'(ext_rst_n), 1);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ack", int'(ack), 0);
        chk("rst_mid_terr", int'(timeout_err), 0);
        chk("rst_mid_cnt", int'(req_cnt), 0);
        model_cnt = 0;
        req = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (PW + 4) begin
            step();
            chk("no_partial_pulse", int'(ext_rst_n), 1);
        end
        run_txn(0, 5, 1'b0, 1'b0, 0, -1);

        // saturation
        for (int i = 0; i < 260; i++) begin
            run_txn(0, 3, 1'b0, 1'b0, 0, -1);
        end
        chk("req_cnt_sat", int'(req_cnt), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
